// File: rtl/rr_replay_pkg.sv
// Shared types and elaboration helpers for the replay-side unpacker.
package rr_replay_pkg;

  localparam int RR_CHANNEL_WIDTH_BITS = 16;
  localparam int RR_MAX_CHANNELS       = 32;

  typedef logic [RR_MAX_CHANNELS-1:0][RR_CHANNEL_WIDTH_BITS-1:0] rr_width_tbl_t;

  typedef enum logic {S_HDR, S_BODY} unpack_state_t;

  function automatic int GET_HDR_W(input int logb_cnt, input int loge_cnt);
    return logb_cnt + loge_cnt;
  endfunction

  // Payload bits carried by the logb channels flagged in bitmap.
  function automatic int unsigned GET_UNIT_LEN(input logic [RR_MAX_CHANNELS-1:0] bitmap,
                                               input rr_width_tbl_t widths);
    int unsigned sum;
    sum = 0;
    for (int i = 0; i < RR_MAX_CHANNELS; i++)
      if (bitmap[i]) sum += 32'(widths[i]);
    return sum;
  endfunction

  function automatic int GET_FULL_W(input int logb_cnt, input int loge_cnt,
                                    input rr_width_tbl_t widths);
    logic [RR_MAX_CHANNELS-1:0] all_logb;
    for (int i = 0; i < RR_MAX_CHANNELS; i++) all_logb[i] = (i < logb_cnt);
    return GET_HDR_W(logb_cnt, loge_cnt) + int'(GET_UNIT_LEN(all_logb, widths));
  endfunction

endpackage

// File: rtl/rr_replay_unpacker_if.sv
// Beat input and unit output handshakes of the replay unpacker.
interface rr_replay_unpacker_if #(
  parameter int AXI_WIDTH    = 512,
  parameter int FULL_WIDTH   = 136,
  parameter int OFFSET_WIDTH = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [AXI_WIDTH-1:0]    in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [FULL_WIDTH-1:0]   out_data;
  logic [OFFSET_WIDTH-1:0] out_len;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, out_len);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_len);
endinterface

// File: rtl/rr_replay_unpacker_len_calc.sv
// rr_unit_len_calc: registers the unit length decoded from a logb bitmap,
// keeping the channel-width adder off the buffer shift path.
module rr_unit_len_calc import rr_replay_pkg::*; #(
  parameter int            LOGB_CHANNEL_CNT = 4,
  parameter int            HDR_W            = 8,
  parameter int            OFFSET_WIDTH     = 8,
  parameter rr_width_tbl_t CHANNEL_WIDTHS   = {RR_MAX_CHANNELS{16'd32}}
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic [LOGB_CHANNEL_CNT-1:0] bitmap,
  output logic [OFFSET_WIDTH-1:0]     len_q
);

  always_ff @(posedge clk) begin
    if (rst)
      len_q <= '0;
    else if (load)
      len_q <= OFFSET_WIDTH'(32'(HDR_W) +
                             GET_UNIT_LEN(RR_MAX_CHANNELS'(bitmap), CHANNEL_WIDTHS));
  end

endmodule

// File: rtl/rr_replay_unpacker.sv
// Re-splits packed storage beats into variable-length log units.
// Optional unit/pad counters: define RR_UNPACK_STATS_EN.
//
//   state  | meaning
//   S_HDR  | waiting for a complete header; skips padding, latches length
//   S_BODY | unit length known; presents unit once all its bits are buffered
module rr_replay_unpacker import rr_replay_pkg::*; #(
  parameter int            LOGB_CHANNEL_CNT = 4,
  parameter int            LOGE_CHANNEL_CNT = 4,
  parameter rr_width_tbl_t CHANNEL_WIDTHS   = {RR_MAX_CHANNELS{16'd32}},
  parameter int            AXI_WIDTH        = 512,
  localparam int           HDR_W            = GET_HDR_W(LOGB_CHANNEL_CNT, LOGE_CHANNEL_CNT),
  localparam int           FULL_WIDTH       = GET_FULL_W(LOGB_CHANNEL_CNT, LOGE_CHANNEL_CNT,
                                                         CHANNEL_WIDTHS),
  localparam int           BUF_W            = AXI_WIDTH + FULL_WIDTH,
  localparam int           OFFSET_WIDTH     = $clog2(FULL_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_replay_unpacker_if.slave  bus,
  output logic [31:0]          unit_cnt,
  output logic [31:0]          pad_cnt
);

  localparam int CNT_W = $clog2(BUF_W + 1);
  localparam int POS_W = $clog2(AXI_WIDTH);

  logic [BUF_W-1:0]        buf_q, buf_shift, buf_next;
  logic [CNT_W-1:0]        cnt_q, cnt_shift, cnt_next, drop;
  logic [POS_W-1:0]        pos_q;
  logic [OFFSET_WIDTH-1:0] len_q;
  logic [FULL_WIDTH-1:0]   len_mask;
  unpack_state_t           state_q;
  logic                    hdr_ok, is_pad, is_hdr, push, pop;
  int unsigned             pos_sum, pos_wrap;

  assign hdr_ok = (cnt_q >= CNT_W'(HDR_W));
  assign is_pad = (state_q == S_HDR) && hdr_ok && (buf_q[HDR_W-1:0] == '0);
  assign is_hdr = (state_q == S_HDR) && hdr_ok && (buf_q[HDR_W-1:0] != '0);

  assign bus.in_ready  = !rst && (cnt_q <= CNT_W'(FULL_WIDTH));
  assign bus.out_valid = !rst && (state_q == S_BODY) && (cnt_q >= CNT_W'(len_q));
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // Upper bits of buf_q beyond cnt_q are kept zero, so the new beat can be OR-ed in.
  assign len_mask     = ~({FULL_WIDTH{1'b1}} << len_q);
  assign bus.out_data = buf_q[FULL_WIDTH-1:0] & len_mask;
  assign bus.out_len  = len_q;

  rr_unit_len_calc #(
    .LOGB_CHANNEL_CNT (LOGB_CHANNEL_CNT),
    .HDR_W            (HDR_W),
    .OFFSET_WIDTH     (OFFSET_WIDTH),
    .CHANNEL_WIDTHS   (CHANNEL_WIDTHS)
  ) u_len_calc (
    .clk    (clk),
    .rst    (rst),
    .load   (is_hdr),
    .bitmap (buf_q[LOGB_CHANNEL_CNT-1:0]),
    .len_q  (len_q)
  );

  always_comb begin
    drop = '0;
    if (is_pad)
      drop = CNT_W'(AXI_WIDTH) - CNT_W'(pos_q);
    else if (pop)
      drop = CNT_W'(len_q);
    buf_shift = buf_q >> drop;
    cnt_shift = cnt_q - drop;
    buf_next  = buf_shift;
    cnt_next  = cnt_shift;
    if (push) begin
      buf_next = buf_shift | (BUF_W'(bus.in_data) << cnt_shift);
      cnt_next = cnt_shift + CNT_W'(AXI_WIDTH);
    end
  end

  // A unit never exceeds one beat, so a single wrap step suffices.
  assign pos_sum  = 32'(pos_q) + 32'(len_q);
  assign pos_wrap = (pos_sum >= 32'(AXI_WIDTH)) ? pos_sum - 32'(AXI_WIDTH) : pos_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q   <= '0;
      cnt_q   <= '0;
      pos_q   <= '0;
      state_q <= S_HDR;
    end else begin
      buf_q <= buf_next;
      cnt_q <= cnt_next;
      case (state_q)
        S_HDR: begin
          if (is_pad)
            pos_q <= '0;
          else if (is_hdr)
            state_q <= S_BODY;
        end
        S_BODY: begin
          if (pop) begin
            pos_q   <= POS_W'(pos_wrap);
            state_q <= S_HDR;
          end
        end
        default: state_q <= S_HDR;
      endcase
    end
  end

`ifdef RR_UNPACK_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      unit_cnt <= '0;
      pad_cnt  <= '0;
    end else begin
      if (pop)    unit_cnt <= unit_cnt + 32'd1;
      if (is_pad) pad_cnt  <= pad_cnt + 32'd1;
    end
  end
`else
  assign unit_cnt = '0;
  assign pad_cnt  = '0;
`endif

endmodule

// File: tb/tb_rr_replay_unpacker.sv
// Directed bench for rr_replay_unpacker: 2 logb channels (8/16 bits), 1 loge, 64-bit beats.
module tb_rr_replay_unpacker;
  import rr_replay_pkg::*;

  localparam int AXI  = 64;
  localparam int FULL = 27;
  localparam int OFFW = 5;
  localparam rr_width_tbl_t TB_WIDTHS = {{(RR_MAX_CHANNELS-2){16'd0}}, 16'd16, 16'd8};

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] unit_cnt, pad_cnt;

  always #5 clk = ~clk;

  rr_replay_unpacker_if #(.AXI_WIDTH(AXI), .FULL_WIDTH(FULL), .OFFSET_WIDTH(OFFW)) bus();

  rr_replay_unpacker #(
    .LOGB_CHANNEL_CNT (2),
    .LOGE_CHANNEL_CNT (1),
    .CHANNEL_WIDTHS   (TB_WIDTHS),
    .AXI_WIDTH        (AXI)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .unit_cnt (unit_cnt),
    .pad_cnt  (pad_cnt)
  );

  int checks = 0;
  int errors = 0;

  logic [26:0] q_data[$];
  logic [4:0]  q_len[$];
  int          beats_acc = 0;

  // Handshakes complete on the following posedge; inputs only move at posedge+1.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      q_data.push_back(bus.out_data);
      q_len.push_back(bus.out_len);
    end
    if (bus.in_valid && bus.in_ready) beats_acc++;
  end

  function automatic logic [26:0] mk_unit(input logic [7:0] p0, input logic [15:0] p1);
    return {p1, p0, 3'b011};
  endfunction

  task automatic ticks(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_beat(input logic [63:0] d);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin @(negedge clk); n++; end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL send_beat: in_ready still %0b after %0d cycles, required 1", bus.in_ready, n);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_units(input int target, input string name);
    int n;
    n = 0;
    while (q_data.size() < target && n < 500) begin @(posedge clk); #1; n++; end
    if (q_data.size() < target) begin
      checks++; errors++;
      $display("FAIL %s timeout: got %0d units, required %0d", name, q_data.size(), target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    ticks(3);
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b, required 0", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, required 0", bus.out_valid); end
    rst = 1'b0;
    ticks(1);
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %b, required 1", bus.in_ready); end
    checks++;
    if (unit_cnt !== 32'd0 || pad_cnt !== 32'd0) begin
      errors++; $display("FAIL rst_counters: got %0d/%0d, required 0/0", unit_cnt, pad_cnt);
    end
  endtask

  task automatic test_single_unit();
    int base;
    logic [26:0] d;
    base = q_data.size();
    bus.out_ready = 1'b1;
    send_beat(64'h529);
    wait_units(base + 1, "single");
    ticks(3);
    d = q_data[base];
    checks++;
    if (q_len[base] !== 5'd11) begin errors++; $display("FAIL single_len: got %0d, required 11", q_len[base]); end
    checks++;
    if (d !== 27'h529) begin errors++; $display("FAIL single_data: got %h, required 529", d); end
    checks++;
    if (d[10:3] !== 8'hA5) begin errors++; $display("FAIL single_payload: got %h, required a5", d[10:3]); end
    checks++;
    if (dut.cnt_q !== '0) begin errors++; $display("FAIL single_cnt: got %0d, required 0", dut.cnt_q); end
`ifdef RR_UNPACK_STATS_EN
    checks++;
    if (pad_cnt !== 32'd1) begin errors++; $display("FAIL single_pad_cnt: got %0d, required 1", pad_cnt); end
`else
    checks++;
    if (pad_cnt !== 32'd0) begin errors++; $display("FAIL single_pad_cnt: got %0d, required 0", pad_cnt); end
`endif
  endtask

  task automatic test_straddle();
    int base;
    logic [26:0]  u[3];
    logic [127:0] s;
    base = q_data.size();
    u[0] = mk_unit(8'h11, 16'h2233);
    u[1] = mk_unit(8'h44, 16'h5566);
    u[2] = mk_unit(8'h77, 16'h8899);
    s = 128'(u[0]) | (128'(u[1]) << 27) | (128'(u[2]) << 54);
    bus.out_ready = 1'b1;
    send_beat(s[63:0]);
    send_beat(s[127:64]);
    wait_units(base + 3, "straddle");
    ticks(3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (q_len[base+i] !== 5'd27 || q_data[base+i] !== u[i]) begin
        errors++;
        $display("FAIL straddle_unit%0d: got len %0d data %h, required len 27 data %h",
                 i, q_len[base+i], q_data[base+i], u[i]);
      end
    end
    checks++;
    if (dut.cnt_q !== '0) begin errors++; $display("FAIL straddle_cnt: got %0d, required 0", dut.cnt_q); end
  endtask

  task automatic test_backpressure();
    int base, base_beats, bad;
    logic [26:0]  u[7];
    logic [191:0] s;
    base = q_data.size();
    base_beats = beats_acc;
    bad = 0;
    s = '0;
    for (int k = 0; k < 7; k++) begin
      u[k] = mk_unit(8'(8'h10 + k), 16'(16'h1000 + k));
      s = s | (192'(u[k]) << (27 * k));
    end
    bus.out_ready = 1'b0;
    fork
      begin
        send_beat(s[63:0]);
        send_beat(s[127:64]);
        send_beat(s[191:128]);
      end
      begin
        for (int c = 0; c < 20; c++) begin
          @(posedge clk); #1;
          if (c >= 3 && (bus.out_valid !== 1'b1 || bus.out_data !== u[0])) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL bp_stable: %0d unstable cycles, required 0", bad); end
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b, required 0", bus.in_ready); end
        checks++;
        if (beats_acc - base_beats != 1) begin
          errors++; $display("FAIL bp_beats_held: got %0d, required 1", beats_acc - base_beats);
        end
        checks++;
        if (q_data.size() != base) begin
          errors++; $display("FAIL bp_no_leak: got %0d units, required 0", q_data.size() - base);
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_units(base + 7, "backpressure");
    ticks(4);
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (q_len[base+k] !== 5'd27 || q_data[base+k] !== u[k]) begin
        errors++;
        $display("FAIL bp_unit%0d: got len %0d data %h, required len 27 data %h",
                 k, q_len[base+k], q_data[base+k], u[k]);
      end
    end
    checks++;
    if (dut.cnt_q !== '0) begin errors++; $display("FAIL bp_cnt: got %0d, required 0", dut.cnt_q); end
  endtask

  task automatic test_loge_only();
    int base;
    base = q_data.size();
    bus.out_ready = 1'b1;
    send_beat(64'h2FBBD4);
    wait_units(base + 2, "loge_only");
    checks++;
    if (q_len[base] !== 5'd3 || q_data[base] !== 27'h4) begin
      errors++; $display("FAIL loge_unit: got len %0d data %h, required len 3 data 4", q_len[base], q_data[base]);
    end
    checks++;
    if (q_len[base+1] !== 5'd19 || q_data[base+1] !== 27'h5F77A) begin
      errors++;
      $display("FAIL loge_next_unit: got len %0d data %h, required len 19 data 5f77a",
               q_len[base+1], q_data[base+1]);
    end
  endtask

  task automatic test_reset_mid_unit();
    int base, n;
    logic [63:0] b;
    base = q_data.size();
    b = 64'h924924 | (64'(mk_unit(8'hC3, 16'h1234)) << 24);
    bus.out_ready = 1'b1;
    send_beat(b);
    wait_units(base + 8, "mid_prefix");
    bus.out_ready = 1'b0;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (bus.out_valid !== 1'b1 || dut.cnt_q !== 7'd40 || bus.out_len !== 5'd27) begin
      errors++;
      $display("FAIL mid_setup: got valid %b cnt %0d len %0d, required 1/40/27",
               bus.out_valid, dut.cnt_q, bus.out_len);
    end
    rst = 1'b1;
    ticks(1);
    rst = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || dut.cnt_q !== '0 || dut.state_q !== S_HDR) begin
      errors++;
      $display("FAIL mid_reset: got valid %b cnt %0d state %0d, required 0/0/S_HDR",
               bus.out_valid, dut.cnt_q, dut.state_q);
    end
    base = q_data.size();
    bus.out_ready = 1'b1;
    send_beat(64'h529);
    wait_units(base + 1, "mid_fresh");
    checks++;
    if (q_len[base] !== 5'd11 || q_data[base] !== 27'h529) begin
      errors++;
      $display("FAIL mid_fresh_unit: got len %0d data %h, required len 11 data 529", q_len[base], q_data[base]);
    end
  endtask

  task automatic test_stats();
    int base, bad;
    rst = 1'b1;
    ticks(1);
    rst = 1'b0;
    base = q_data.size();
    bad = 0;
    bus.out_ready = 1'b1;
    send_beat(64'h4924);
    send_beat(64'h0);
    wait_units(base + 5, "stats");
    ticks(5);
    for (int i = 0; i < 5; i++)
      if (q_len[base+i] !== 5'd3 || q_data[base+i] !== 27'h4) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stats_units: %0d wrong units, required 0", bad); end
    checks++;
    if (dut.cnt_q !== '0) begin errors++; $display("FAIL stats_cnt: got %0d, required 0", dut.cnt_q); end
`ifdef RR_UNPACK_STATS_EN
    checks++;
    if (unit_cnt !== 32'd5 || pad_cnt !== 32'd2) begin
      errors++; $display("FAIL stats_counters: got %0d/%0d, required 5/2", unit_cnt, pad_cnt);
    end
`else
    checks++;
    if (unit_cnt !== 32'd0 || pad_cnt !== 32'd0) begin
      errors++; $display("FAIL stats_counters: got %0d/%0d, required 0/0", unit_cnt, pad_cnt);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_unit();
    test_straddle();
    test_backpressure();
    test_loge_only();
    test_reset_mid_unit();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
